axis_s: RTL and testbench
=========================

AXIS_S -- requirements
Module: axis_s

Interface
REQ-001 SHALL have parameter DEPTH, default 4: receive FIFO entries; power of two, 2..16.
REQ-002 SHALL have port s_axis_aclk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port s_axis_areset, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port s_axis_tdata, input, 8: stream data from the upstream master.
REQ-005 SHALL have port s_axis_tvalid, input, 1: upstream beat valid.
REQ-006 SHALL have port s_axis_tlast, input, 1: marks the final beat of a packet.
REQ-007 SHALL have port s_axis_tready, output, 1: this block accepts a beat.
REQ-008 SHALL have port rd_en, input, 1: local consumer pops the FIFO head.
REQ-009 SHALL have port dout, output, 8: FIFO head data (show-ahead).
REQ-010 SHALL have port dout_last, output, 1: tlast stored with the FIFO head.
REQ-011 SHALL have port dout_valid, output, 1: FIFO not empty.
REQ-012 SHALL have port pkt_done, output, 1: one-cycle pulse per accepted tlast beat.
REQ-013 SHALL have port pkt_len, output, 8: beat count of the last completed packet.
REQ-014 SHALL have port pkt_cnt, output, 16: completed-packet count; present only under AXIS_S_PKT_CNT_EN.

Function
REQ-015 SHALL accept a beat only in a cycle where s_axis_tvalid and s_axis_tready are both high at the rising edge.
REQ-016 SHALL drive s_axis_tready = not full and not s_axis_areset (combinational), independent of s_axis_tvalid.
REQ-017 SHALL store {tlast, tdata} of each accepted beat in FIFO order; dout/dout_last/dout_valid reflect it one cycle after acceptance when the FIFO was empty.
REQ-018 SHALL pop the head on rd_en while dout_valid is high; rd_en while empty is ignored with no state change.
REQ-019 SHALL, when full, hold tready low even if rd_en is high that cycle; the write is accepted the following cycle.
REQ-020 SHALL allow simultaneous accept and pop when not full and not empty; occupancy unchanged.
REQ-021 SHALL track pointers with DEPTH-wrapping addresses plus a count of width log2(DEPTH)+1; full = count==DEPTH.
REQ-022 SHALL run a two-state FSM: IDLE -> IN_PKT on an accepted beat with tlast=0; IN_PKT -> IDLE on an accepted beat with tlast=1; IDLE stays IDLE on an accepted tlast=1 beat (single-beat packet).
REQ-023 SHALL count accepted beats in the current packet in an 8-bit counter saturating at 255; on the tlast beat, pkt_len is loaded with counter+1 (saturated), the counter clears, and pkt_done pulses for exactly the next cycle.
REQ-024 SHALL hold pkt_len until the next completed packet.

Reset
REQ-025 SHALL, while s_axis_areset is high, force s_axis_tready=0, dout_valid=0, dout=0, dout_last=0, pkt_done=0, pkt_len=0, pkt_cnt=0, FSM=IDLE, beat counter=0, FIFO empty.
REQ-026 SHALL discard a partially received packet and FIFO contents on reset mid-operation; no pkt_done is produced for it.
REQ-027 SHALL raise s_axis_tready in the first cycle after reset deasserts.

Configuration
REQ-028 SHALL, with AXIS_S_PKT_CNT_EN defined, provide pkt_cnt incrementing by 1 per pkt_done and wrapping 0xFFFF -> 0x0000.
REQ-029 SHALL, without AXIS_S_PKT_CNT_EN, omit the pkt_cnt port and its register; all other behaviour is identical.

Verification
REQ-030 SHALL verify reset: assert reset mid-packet after 2 beats -> all outputs 0, tready 0; after release, tready=1, FIFO empty, next tlast beat gives pkt_len=1.
REQ-031 SHALL verify a single packet: beats 0x11,0x22,0x33 (tlast on 0x33), rd_en=1 -> dout sequence 0x11,0x22,0x33, dout_last only on 0x33, pkt_len=3, one pkt_done pulse.
REQ-032 SHALL verify full backpressure: DEPTH=4, rd_en=0, tvalid held high with 6 beats -> exactly 4 accepted, tready low; one rd_en pulse -> 5th beat accepted the following cycle.
REQ-033 SHALL verify an empty pop: rd_en=1 with FIFO empty -> dout_valid stays 0; later beat 0xA5 appears intact.
REQ-034 SHALL verify saturation and count: 300-beat packet -> pkt_len=255; with AXIS_S_PKT_CNT_EN, 5 packets -> pkt_cnt=5.
REQ-035 SHALL verify simultaneous accept and pop at half occupancy for 10 cycles -> occupancy constant, data order preserved.

Source files
------------

// File: rtl/axis_s.sv
// AXI4-Stream slave with a show-ahead receive FIFO and packet-length tracking.
// Optional completed-packet counter port pkt_cnt is enabled by defining AXIS_S_PKT_CNT_EN.
`timescale 1ns/1ps
module axis_s #(
    parameter int DEPTH = 4
) (
    input  logic       s_axis_aclk,
    input  logic       s_axis_areset,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    input  logic       s_axis_tlast,
    output logic       s_axis_tready,
    input  logic       rd_en,
    output logic [7:0] dout,
    output logic       dout_last,
    output logic       dout_valid,
    output logic       pkt_done,
    output logic [7:0] pkt_len
`ifdef AXIS_S_PKT_CNT_EN
    ,
    output logic [15:0] pkt_cnt
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {
        IDLE,
        IN_PKT
    } state_t;

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          accept;
    logic          pop;
    state_t        state;
    logic [7:0]    beat_cnt;
    logic [7:0]    beat_next;

    assign full          = (count == FULL_CNT);
    assign empty         = (count == '0);
    assign s_axis_tready = !full && !s_axis_areset;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign pop           = rd_en && !empty;

    // Head is gated while empty so stale storage never shows on dout.
    assign dout_valid = !empty;
    assign dout       = empty ? '0 : mem[rd_ptr][7:0];
    assign dout_last  = !empty && mem[rd_ptr][8];

    always_ff @(posedge s_axis_aclk) begin
        if (accept) begin
            mem[wr_ptr] <= {s_axis_tlast, s_axis_tdata};
        end
    end

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign beat_next = (beat_cnt == 8'hFF) ? 8'hFF : beat_cnt + 8'd1;

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            state    <= IDLE;
            beat_cnt <= '0;
            pkt_done <= 1'b0;
            pkt_len  <= '0;
`ifdef AXIS_S_PKT_CNT_EN
            pkt_cnt  <= '0;
`endif
        end else begin
            pkt_done <= 1'b0;
            if (accept) begin
                if (s_axis_tlast) begin
                    pkt_len  <= beat_next;
                    beat_cnt <= '0;
                    pkt_done <= 1'b1;
`ifdef AXIS_S_PKT_CNT_EN
                    pkt_cnt  <= pkt_cnt + 16'd1;
`endif
                end else begin
                    beat_cnt <= beat_next;
                end
                case (state)
                    IDLE:    state <= s_axis_tlast ? IDLE : IN_PKT;
                    IN_PKT:  state <= s_axis_tlast ? IDLE : IN_PKT;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axis_s.sv
// Self-checking bench for axis_s: vector table plus scoreboard-driven sequences.
`timescale 1ns/1ps
module tb_axis_s;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_axis_tdata = '0;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tlast = 1'b0;
    logic       s_axis_tready;
    logic       rd_en = 1'b0;
    logic [7:0] dout;
    logic       dout_last;
    logic       dout_valid;
    logic       pkt_done;
    logic [7:0] pkt_len;
`ifdef AXIS_S_PKT_CNT_EN
    logic [15:0] pkt_cnt;
`endif

    axis_s #(.DEPTH(DEPTH)) dut (
        .s_axis_aclk   (clk),
        .s_axis_areset (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .rd_en         (rd_en),
        .dout          (dout),
        .dout_last     (dout_last),
        .dout_valid    (dout_valid),
        .pkt_done      (pkt_done),
        .pkt_len       (pkt_len)
`ifdef AXIS_S_PKT_CNT_EN
        ,
        .pkt_cnt       (pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [8:0]  sb[$];
    int unsigned m_beats = 0;
    logic [7:0]  m_len = '0;
    logic [15:0] m_cnt = '0;
    logic        m_done = 1'b0;
    logic        last_acc = 1'b0;
    int          dut_acc = 0;

    typedef struct {
        logic       tv;
        logic [7:0] d;
        logic       l;
        logic       rd;
        logic       ev;
        logic [7:0] ed;
        logic       el;
        logic       edn;
        logic [7:0] elen;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; drives one cycle and checks both sides of the rising edge.
    task automatic step(input logic tv, input logic [7:0] d, input logic l, input logic rd);
        logic acc;
        logic pop;
        s_axis_tvalid = tv;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        rd_en         = rd;
        #1;
        check("tready", {31'd0, s_axis_tready}, {31'd0, sb.size() < DEPTH});
        if (s_axis_tready && tv) dut_acc++;
        acc = tv && (sb.size() < DEPTH);
        pop = rd && (sb.size() > 0);
        last_acc = acc;
        if (pop) begin
            check("pop_data", {23'd0, dout_last, dout}, {23'd0, sb[0]});
            void'(sb.pop_front());
        end
        m_done = 1'b0;
        if (acc) begin
            sb.push_back({l, d});
            if (l) begin
                m_len   = (m_beats >= 255) ? 8'hFF : 8'(m_beats + 1);
                m_beats = 0;
                m_done  = 1'b1;
                m_cnt   = m_cnt + 16'd1;
            end else begin
                m_beats = (m_beats >= 255) ? 255 : m_beats + 1;
            end
        end
        @(posedge clk);
        #1;
        check("dout_valid", {31'd0, dout_valid}, {31'd0, sb.size() > 0});
        if (sb.size() > 0)
            check("head", {23'd0, dout_last, dout}, {23'd0, sb[0]});
        else
            check("head_empty", {23'd0, dout_last, dout}, 32'd0);
        check("pkt_done", {31'd0, pkt_done}, {31'd0, m_done});
        check("pkt_len", {24'd0, pkt_len}, {24'd0, m_len});
`ifdef AXIS_S_PKT_CNT_EN
        check("pkt_cnt_model", {16'd0, pkt_cnt}, {16'd0, m_cnt});
`endif
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        rd_en         = 1'b0;
        #1;
        check("rst_tready", {31'd0, s_axis_tready}, 32'd0);
        check("rst_valid", {31'd0, dout_valid}, 32'd0);
        check("rst_dout", {23'd0, dout_last, dout}, 32'd0);
        check("rst_done", {31'd0, pkt_done}, 32'd0);
        check("rst_len", {24'd0, pkt_len}, 32'd0);
`ifdef AXIS_S_PKT_CNT_EN
        check("rst_cnt", {16'd0, pkt_cnt}, 32'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_tready", {31'd0, s_axis_tready}, 32'd1);
        check("post_rst_valid", {31'd0, dout_valid}, 32'd0);
        sb.delete();
        m_beats = 0;
        m_len   = '0;
        m_cnt   = '0;
        m_done  = 1'b0;
    endtask

    initial begin
        // tv, d, l, rd | valid, dout, last, done, len (after the edge)
        tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 8'd0};
        tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 8'd0};
        tbl[2] = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 8'd3};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'd3};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'd3};
        tbl[5] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 8'd1};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 8'd1};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'd1};

        do_reset();

        // Single packet, then pop on empty, then an isolated beat
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].tv, tbl[i].d, tbl[i].l, tbl[i].rd);
            check($sformatf("tbl%0d_valid", i), {31'd0, dout_valid}, {31'd0, tbl[i].ev});
            check($sformatf("tbl%0d_dout", i), {24'd0, dout}, {24'd0, tbl[i].ed});
            check($sformatf("tbl%0d_last", i), {31'd0, dout_last}, {31'd0, tbl[i].el});
            check($sformatf("tbl%0d_done", i), {31'd0, pkt_done}, {31'd0, tbl[i].edn});
            check($sformatf("tbl%0d_len", i), {24'd0, pkt_len}, {24'd0, tbl[i].elen});
        end

        // Full backpressure: six beats offered, only DEPTH taken
        begin
            int k;
            k = 0;
            dut_acc = 0;
            for (int c = 0; c < 6; c++) begin
                step(1'b1, 8'hB0 + 8'(k), k == 5, 1'b0);
                if (last_acc) k++;
            end
            check("bp_accepted", dut_acc, 32'd4);
            check("bp_tready_low", {31'd0, s_axis_tready}, 32'd0);
            step(1'b1, 8'hB0 + 8'(k), k == 5, 1'b1);
            check("bp_full_rd_cycle", dut_acc, 32'd4);
            step(1'b1, 8'hB0 + 8'(k), k == 5, 1'b0);
            check("bp_fifth", dut_acc, 32'd5);
            for (int c = 0; c < 4; c++) step(1'b0, 8'h00, 1'b0, 1'b1);
            step(1'b1, 8'hB5, 1'b1, 1'b0);
            check("bp_pkt_len", {24'd0, pkt_len}, 32'd6);
            step(1'b0, 8'h00, 1'b0, 1'b1);
        end

        // Simultaneous accept and pop at half occupancy
        step(1'b1, 8'hC0, 1'b0, 1'b0);
        step(1'b1, 8'hC1, 1'b0, 1'b0);
        dut_acc = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'hC2 + 8'(i), i == 9, 1'b1);
        end
        check("half_acc", dut_acc, 32'd10);
        for (int i = 0; i < 2; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
        check("half_drained", {31'd0, dout_valid}, 32'd0);

        // Long packet saturates the length
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 8'(i), i == 299, 1'b1);
        end
        check("sat_len", {24'd0, pkt_len}, 32'd255);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Reset mid-packet discards the partial packet
        step(1'b1, 8'hD0, 1'b0, 1'b0);
        step(1'b1, 8'hD1, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 8'hE7, 1'b1, 1'b0);
        check("after_rst_len", {24'd0, pkt_len}, 32'd1);
        check("after_rst_head", {23'd0, dout_last, dout}, 32'h1E7);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Four more two-beat packets
        for (int p = 0; p < 4; p++) begin
            step(1'b1, 8'hF0 + 8'(p), 1'b0, 1'b1);
            step(1'b1, 8'hF8 + 8'(p), 1'b1, 1'b1);
        end
        check("two_beat_len", {24'd0, pkt_len}, 32'd2);
`ifdef AXIS_S_PKT_CNT_EN
        check("pkt_cnt_five", {16'd0, pkt_cnt}, 32'd5);
`endif
        step(1'b0, 8'h00, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
